// File: rtl/lidar_packet_parser.sv
// LiDAR packet parser: frames 47-byte measurement packets, checks CRC-8 (poly 0x4D),
// divides the angle span into per-sample steps and emits one record per sample.
module lidar_packet_parser #(
    parameter int POINTS        = 12,
    parameter int MIN_INTENSITY = 0,
    parameter int FULL_CIRCLE   = 36000
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid_in,
    output logic [15:0] first_angle_out,
    output logic [15:0] interval_angle_out,
    output logic [15:0] sample_index_out,
    output logic [15:0] distance_out,
    output logic        data_valid_out,
    output logic [15:0] speed_out,
    output logic        packet_done_out,
    output logic        crc_error_out,
    output logic        overrun_out
);

    localparam int BODY_LEN = 3 * POINTS + 8;
    localparam int SAMP_END = 4 + 3 * POINTS;
    localparam int BW       = $clog2(BODY_LEN);
    localparam int IW       = $clog2(POINTS + 1);
    localparam logic [16:0] DIVISOR = 17'(POINTS - 1);
    localparam logic [16:0] CIRCLE  = 17'(FULL_CIRCLE);
    localparam logic [8:0]  MIN_I   = 9'(MIN_INTENSITY);

    typedef enum logic [2:0] {
        S_HUNT   = 3'd0,
        S_VERLEN = 3'd1,
        S_BODY   = 3'd2,
        S_CRC    = 3'd3,
        S_DIVIDE = 3'd4,
        S_EMIT   = 3'd5
    } state_t;

    function automatic logic [7:0] crc8_update(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc;
        for (int i = 7; i >= 0; i--) begin
            if (c[7] ^ data[i]) c = {c[6:0], 1'b0} ^ 8'h4D;
            else                c = {c[6:0], 1'b0};
        end
        return c;
    endfunction

    state_t          state_q;
    logic [7:0]      crc_q;
    logic [BW-1:0]   bcnt_q;
    logic [1:0]      phase_q;
    logic [IW-1:0]   samp_q;
    logic [IW-1:0]   emit_idx_q;
    logic [15:0]     dist_q;
    logic [15:0]     speed_lat_q;
    logic [15:0]     start_q;
    logic [15:0]     end_q;
    logic [15:0]     buf_q [POINTS];
    logic [16:0]     rem_q;
    logic [15:0]     dvd_q;
    logic [4:0]      div_cnt_q;
    logic [15:0]     first_angle_q, interval_q, index_q, distance_q, speed_q;
    logic            data_valid_q, packet_done_q, crc_error_q, overrun_q;

    logic [16:0]     diff_d;
    logic [16:0]     rem_d;
    logic [15:0]     dvd_d;

    // Angle span with wrap-around and one restoring-division step (quotient bits shift into dvd).
    always_comb begin
        diff_d = 17'd0;
        rem_d  = 17'd0;
        dvd_d  = 16'd0;
        if (end_q >= start_q) diff_d = {1'b0, end_q} - {1'b0, start_q};
        else                  diff_d = {1'b0, end_q} + CIRCLE - {1'b0, start_q};
        if ({rem_q, dvd_q[15]} >= {1'b0, DIVISOR}) begin
            rem_d = 17'({rem_q, dvd_q[15]} - {1'b0, DIVISOR});
            dvd_d = {dvd_q[14:0], 1'b1};
        end else begin
            rem_d = {rem_q[15:0], dvd_q[15]};
            dvd_d = {dvd_q[14:0], 1'b0};
        end
    end

    // Parser FSM, field capture, divider sequencing and registered outputs.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q       <= S_HUNT;
            crc_q         <= 8'd0;
            bcnt_q        <= '0;
            phase_q       <= 2'd0;
            samp_q        <= '0;
            emit_idx_q    <= '0;
            dist_q        <= 16'd0;
            speed_lat_q   <= 16'd0;
            start_q       <= 16'd0;
            end_q         <= 16'd0;
            for (int i = 0; i < POINTS; i++) buf_q[i] <= 16'd0;
            rem_q         <= 17'd0;
            dvd_q         <= 16'd0;
            div_cnt_q     <= 5'd0;
            first_angle_q <= 16'd0;
            interval_q    <= 16'd0;
            index_q       <= 16'd0;
            distance_q    <= 16'd0;
            speed_q       <= 16'd0;
            data_valid_q  <= 1'b0;
            packet_done_q <= 1'b0;
            crc_error_q   <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            data_valid_q  <= 1'b0;
            packet_done_q <= 1'b0;
            crc_error_q   <= 1'b0;
            overrun_q     <= 1'b0;
            case (state_q)
                S_HUNT: begin
                    if (byte_valid_in && byte_in == 8'h54) begin
                        crc_q   <= crc8_update(8'h00, 8'h54);
                        state_q <= S_VERLEN;
                    end
                end
                S_VERLEN: begin
                    if (byte_valid_in) begin
                        if (byte_in == 8'h2C) begin
                            crc_q   <= crc8_update(crc_q, byte_in);
                            bcnt_q  <= '0;
                            phase_q <= 2'd0;
                            samp_q  <= '0;
                            state_q <= S_BODY;
                        end else if (byte_in == 8'h54) begin
                            crc_q   <= crc8_update(8'h00, 8'h54);
                        end else begin
                            state_q <= S_HUNT;
                        end
                    end
                end
                S_BODY: begin
                    if (byte_valid_in) begin
                        crc_q  <= crc8_update(crc_q, byte_in);
                        bcnt_q <= bcnt_q + BW'(1);
                        if (bcnt_q == BW'(0))      speed_lat_q[7:0]  <= byte_in;
                        else if (bcnt_q == BW'(1)) speed_lat_q[15:8] <= byte_in;
                        else if (bcnt_q == BW'(2)) start_q[7:0]      <= byte_in;
                        else if (bcnt_q == BW'(3)) start_q[15:8]     <= byte_in;
                        else if (bcnt_q < BW'(SAMP_END)) begin
                            case (phase_q)
                                2'd0: begin
                                    dist_q[7:0] <= byte_in;
                                    phase_q     <= 2'd1;
                                end
                                2'd1: begin
                                    dist_q[15:8] <= byte_in;
                                    phase_q      <= 2'd2;
                                end
                                default: begin
                                    buf_q[samp_q] <= ({1'b0, byte_in} < MIN_I) ? 16'd0 : dist_q;
                                    samp_q        <= samp_q + IW'(1);
                                    phase_q       <= 2'd0;
                                end
                            endcase
                        end
                        else if (bcnt_q == BW'(SAMP_END))     end_q[7:0]  <= byte_in;
                        else if (bcnt_q == BW'(SAMP_END + 1)) end_q[15:8] <= byte_in;
                        if (bcnt_q == BW'(BODY_LEN - 1)) state_q <= S_CRC;
                    end
                end
                S_CRC: begin
                    if (byte_valid_in) begin
                        if (byte_in == crc_q) begin
                            speed_q   <= speed_lat_q;
                            rem_q     <= {16'd0, diff_d[16]};
                            dvd_q     <= diff_d[15:0];
                            div_cnt_q <= 5'd0;
                            state_q   <= S_DIVIDE;
                        end else begin
                            crc_error_q <= 1'b1;
                            state_q     <= S_HUNT;
                        end
                    end
                end
                S_DIVIDE: begin
                    overrun_q <= byte_valid_in;
                    if (div_cnt_q == 5'd16) begin
                        interval_q <= dvd_q;
                        emit_idx_q <= '0;
                        state_q    <= S_EMIT;
                    end else begin
                        rem_q     <= rem_d;
                        dvd_q     <= dvd_d;
                        div_cnt_q <= div_cnt_q + 5'd1;
                    end
                end
                S_EMIT: begin
                    overrun_q <= byte_valid_in;
                    if (emit_idx_q == IW'(POINTS)) begin
                        packet_done_q <= 1'b1;
                        state_q       <= S_HUNT;
                    end else begin
                        data_valid_q  <= 1'b1;
                        first_angle_q <= start_q;
                        index_q       <= 16'(emit_idx_q);
                        distance_q    <= buf_q[emit_idx_q];
                        emit_idx_q    <= emit_idx_q + IW'(1);
                    end
                end
                default: state_q <= S_HUNT;
            endcase
        end
    end

    assign first_angle_out    = first_angle_q;
    assign interval_angle_out = interval_q;
    assign sample_index_out   = index_q;
    assign distance_out       = distance_q;
    assign data_valid_out     = data_valid_q;
    assign speed_out          = speed_q;
    assign packet_done_out    = packet_done_q;
    assign crc_error_out      = crc_error_q;
    assign overrun_out        = overrun_q;

endmodule
